// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Purpose  : Shared FSM encodings, control-vector type and helpers for the
//             pipeline hazard controller.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'd0,
        HZ_WAIT = 2'd1,
        HZ_ERR  = 2'd2
    } hz_state_t;

    localparam int unsigned c_CNT_W_DEFAULT = 32;
    localparam int unsigned c_WAIT_W        = 8;

    typedef struct packed {
        logic pc_we;
        logic if_stall;
        logic id_stall;
        logic ex_stall;
        logic mem_stall;
        logic wb_stall;
        logic id_flush;
        logic ex_flush;
        logic mem_flush;
        logic wb_flush;
    } hz_ctrl_t;

    // A source operand conflicts when it is actually read and names the load target.
    function automatic logic reg_hit(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Pipeline-side hazard signals and the controller's responses.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_re;
    logic             ex_rf_we;
    logic [4:0]       ex_rf_dst;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_we;
    logic             if_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             mem_stall;
    logic             wb_stall;
    logic             id_flush;
    logic             ex_flush;
    logic             mem_flush;
    logic             wb_flush;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_re, ex_rf_we,
               ex_rf_dst, ex_branch_taken, mem_req, mem_ack,
        input  pc_we, if_stall, id_stall, ex_stall, mem_stall, wb_stall,
               id_flush, ex_flush, mem_flush, wb_flush, err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_re, ex_rf_we,
               ex_rf_dst, ex_branch_taken, mem_req, mem_ack,
        output pc_we, if_stall, id_stall, ex_stall, mem_stall, wb_stall,
               id_flush, ex_flush, mem_flush, wb_flush, err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_hazard_detect
//  Purpose  : Combinational load-use comparator between ID and EX.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  wire logic [4:0] i_id_rs,
    input  wire logic [4:0] i_id_rt,
    input  wire logic       i_id_uses_rs,
    input  wire logic       i_id_uses_rt,
    input  wire logic       i_ex_mem_re,
    input  wire logic       i_ex_rf_we,
    input  wire logic [4:0] i_ex_rf_dst,
    output logic            o_load_use
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_ex_mem_re && i_ex_rf_we && (i_ex_rf_dst != 5'd0) &&
                        (reg_hit(i_id_uses_rs, i_id_rs, i_ex_rf_dst) ||
                         reg_hit(i_id_uses_rt, i_id_rt, i_ex_rf_dst));
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush scheduler for the 5-stage pipeline with a
//             memory-wait FSM, timeout error and performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = c_CNT_W_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t             r_state;
    hz_state_t             w_state_nxt;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_WAIT_W-1:0]   w_wait_cnt_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;
    logic                  w_load_use;
    logic                  w_freeze;
    hz_ctrl_t              w_ctrl;

    pipe_hazard_ctrl_hazard_detect u_detect (
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .i_id_uses_rs (bus.id_uses_rs),
        .i_id_uses_rt (bus.id_uses_rt),
        .i_ex_mem_re  (bus.ex_mem_re),
        .i_ex_rf_we   (bus.ex_rf_we),
        .i_ex_rf_dst  (bus.ex_rf_dst),
        .o_load_use   (w_load_use)
    );

    assign w_freeze = ((r_state == HZ_RUN)  && bus.mem_req && !bus.mem_ack) ||
                      ((r_state == HZ_WAIT) && !bus.mem_ack) ||
                       (r_state == HZ_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HZ_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (!w_ctrl.pc_we) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            // id_flush is raised only by a taken branch.
            if (w_ctrl.id_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            HZ_RUN: begin
                w_wait_cnt_nxt = '0;
                if (bus.mem_req && !bus.mem_ack) begin
                    w_state_nxt = HZ_WAIT;
                end
            end
            HZ_WAIT: begin
                if (bus.mem_ack) begin
                    w_state_nxt    = HZ_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = HZ_ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            HZ_ERR: begin
                w_state_nxt = HZ_ERR;
            end
            default: begin
                w_state_nxt    = HZ_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_ctrl       = '0;
        w_ctrl.pc_we = 1'b1;
        if (rst) begin
            w_ctrl = '0;
        end else if (w_freeze) begin
            // WB keeps draining as bubbles so a held MEM result is not written twice.
            w_ctrl.pc_we     = 1'b0;
            w_ctrl.if_stall  = 1'b1;
            w_ctrl.id_stall  = 1'b1;
            w_ctrl.ex_stall  = 1'b1;
            w_ctrl.mem_stall = 1'b1;
            w_ctrl.wb_flush  = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_ctrl.id_flush = 1'b1;
            w_ctrl.ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_we    = 1'b0;
            w_ctrl.if_stall = 1'b1;
            w_ctrl.id_stall = 1'b1;
            w_ctrl.ex_flush = 1'b1;
        end
    end

    assign bus.pc_we     = w_ctrl.pc_we;
    assign bus.if_stall  = w_ctrl.if_stall;
    assign bus.id_stall  = w_ctrl.id_stall;
    assign bus.ex_stall  = w_ctrl.ex_stall;
    assign bus.mem_stall = w_ctrl.mem_stall;
    assign bus.wb_stall  = w_ctrl.wb_stall;
    assign bus.id_flush  = w_ctrl.id_flush;
    assign bus.ex_flush  = w_ctrl.ex_flush;
    assign bus.mem_flush = w_ctrl.mem_flush;
    assign bus.wb_flush  = w_ctrl.wb_flush;
    assign bus.err       = (r_state == HZ_ERR);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl against a cycle model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int unsigned c_TO = 4;

    logic clk;
    logic rst;
    pipe_hazard_ctrl_if #(.CNT_W(32)) hif ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(c_TO), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: memory access outstanding, error latched, completed waits.
    bit          m_waiting;
    bit          m_err;
    int          m_waits;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    // Vector: pc_we, if/id/ex/mem/wb stall, id/ex/mem/wb flush, err.
    function automatic logic [10:0] dut_out();
        return {hif.pc_we, hif.if_stall, hif.id_stall, hif.ex_stall, hif.mem_stall,
                hif.wb_stall, hif.id_flush, hif.ex_flush, hif.mem_flush, hif.wb_flush,
                hif.err};
    endfunction

    function automatic logic [10:0] model_out();
        bit frz, lu;
        frz = m_err || (m_waiting ? !hif.mem_ack : (hif.mem_req && !hif.mem_ack));
        lu  = hif.ex_mem_re && hif.ex_rf_we && hif.ex_rf_dst != 0 &&
              ((hif.id_uses_rs && hif.id_rs == hif.ex_rf_dst) ||
               (hif.id_uses_rt && hif.id_rt == hif.ex_rf_dst));
        if (rst)                     return {10'b0, m_err};
        if (frz)                     return {1'b0, 5'b11110, 4'b0001, m_err};
        if (hif.ex_branch_taken)     return {1'b1, 5'b00000, 4'b1100, m_err};
        if (lu)                      return {1'b0, 5'b11000, 4'b0100, m_err};
        return {1'b1, 5'b00000, 4'b0000, m_err};
    endfunction

    task automatic model_update(input logic [10:0] e);
        if (rst) begin
            m_waiting = 0; m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[10]) m_stall = m_stall + 1;
            if (e[4])   m_flush = m_flush + 1;
            if (m_err) begin
            end else if (m_waiting) begin
                if (hif.mem_ack) m_waiting = 0;
                else begin
                    m_waits++;
                    if (m_waits >= c_TO) begin m_err = 1; m_waiting = 0; end
                end
            end else if (hif.mem_req && !hif.mem_ack) begin
                m_waiting = 1;
                m_waits   = 0;
            end
        end
    endtask

    task automatic tick();
        logic [10:0] e;
        e = model_out();
        @(posedge clk);
        model_update(e);
        #1;
    endtask

    task automatic set_idle();
        @(negedge clk);
        hif.id_rs = 0; hif.id_rt = 0; hif.id_uses_rs = 0; hif.id_uses_rt = 0;
        hif.ex_mem_re = 0; hif.ex_rf_we = 0; hif.ex_rf_dst = 0;
        hif.ex_branch_taken = 0; hif.mem_req = 0; hif.mem_ack = 0;
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        set_idle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        hif.mem_req = 1; hif.ex_branch_taken = 1;
        #1;
        tick();
        n_checks++;
        if (dut_out() !== 11'b0) $display("FAIL reset_outputs got=%b want=%b", dut_out(), 11'b0);
        else n_pass++;
        tick();
        n_checks++;
        if (hif.stall_cnt !== 32'd0 || hif.flush_cnt !== 32'd0)
            $display("FAIL reset_counters got=%0d/%0d want=0/0", hif.stall_cnt, hif.flush_cnt);
        else n_pass++;
        set_idle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (dut_out() !== model_out()) $display("FAIL idle_after_reset got=%b want=%b", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic [10:0] lit;
        lit = 11'b0_11000_0100_0;
        do_reset();
        hif.ex_mem_re = 1; hif.ex_rf_we = 1; hif.ex_rf_dst = 8; hif.id_rs = 8; hif.id_uses_rs = 1;
        #1;
        n_checks++;
        if (dut_out() !== lit) $display("FAIL load_use_rs got=%b want=%b", dut_out(), lit);
        else n_pass++;
        tick();
        n_checks++;
        if (hif.stall_cnt !== 32'd1) $display("FAIL load_use_stall_cnt got=%0d want=1", hif.stall_cnt);
        else n_pass++;
        set_idle();
        hif.ex_mem_re = 1; hif.ex_rf_we = 1; hif.ex_rf_dst = 0; hif.id_rs = 0; hif.id_uses_rs = 1;
        #1;
        n_checks++;
        if (dut_out() !== model_out() || !hif.pc_we) $display("FAIL load_use_r0 got=%b want=%b", dut_out(), model_out());
        else n_pass++;
        hif.ex_rf_dst = 8; hif.id_rs = 8; hif.id_uses_rs = 0;
        #1;
        n_checks++;
        if (dut_out() !== model_out() || !hif.pc_we) $display("FAIL load_use_unused got=%b want=%b", dut_out(), model_out());
        else n_pass++;
        hif.id_rt = 8; hif.id_uses_rt = 1;
        #1;
        n_checks++;
        if (dut_out() !== lit) $display("FAIL load_use_rt got=%b want=%b", dut_out(), lit);
        else n_pass++;
        hif.ex_mem_re = 0;
        #1;
        n_checks++;
        if (dut_out() !== model_out() || !hif.pc_we) $display("FAIL not_a_load got=%b want=%b", dut_out(), model_out());
        else n_pass++;
        tick();
    endtask

    task automatic test_branch();
        logic [10:0] lit;
        lit = 11'b1_00000_1100_0;
        do_reset();
        hif.ex_branch_taken = 1;
        hif.ex_mem_re = 1; hif.ex_rf_we = 1; hif.ex_rf_dst = 8; hif.id_rs = 8; hif.id_uses_rs = 1;
        #1;
        n_checks++;
        if (dut_out() !== lit) $display("FAIL branch_over_load_use got=%b want=%b", dut_out(), lit);
        else n_pass++;
        tick();
        n_checks++;
        if (hif.flush_cnt !== 32'd1 || hif.stall_cnt !== 32'd0)
            $display("FAIL branch_counters got=%0d/%0d want=1/0", hif.flush_cnt, hif.stall_cnt);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        logic [10:0] lit;
        lit = 11'b0_11110_0001_0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            hif.mem_req = 1;
            #1;
            n_checks++;
            if (dut_out() !== lit) $display("FAIL mem_wait_freeze%0d got=%b want=%b", i, dut_out(), lit);
            else n_pass++;
            tick();
        end
        set_idle();
        hif.mem_req = 1; hif.mem_ack = 1;
        #1;
        n_checks++;
        if (dut_out() !== 11'b1_00000_0000_0) $display("FAIL mem_ack_cycle got=%b want=%b", dut_out(), 11'b1_00000_0000_0);
        else n_pass++;
        tick();
        set_idle();
        n_checks++;
        if (dut_out() !== model_out() || !hif.pc_we) $display("FAIL mem_back_to_run got=%b want=%b", dut_out(), model_out());
        else n_pass++;
        n_checks++;
        if (hif.stall_cnt !== 32'd3) $display("FAIL mem_wait_stall_cnt got=%0d want=3", hif.stall_cnt);
        else n_pass++;
    endtask

    task automatic test_same_cycle_ack();
        do_reset();
        hif.mem_req = 1; hif.mem_ack = 1;
        #1;
        n_checks++;
        if (dut_out() !== model_out() || !hif.pc_we) $display("FAIL same_cycle_ack got=%b want=%b", dut_out(), model_out());
        else n_pass++;
        tick();
        set_idle();
        n_checks++;
        if (dut_out() !== model_out() || !hif.pc_we) $display("FAIL same_cycle_ack_run got=%b want=%b", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 1 + c_TO; i++) begin
            set_idle();
            hif.mem_req = 1;
            #1;
            n_checks++;
            if (dut_out() !== 11'b0_11110_0001_0) $display("FAIL timeout_freeze%0d got=%b want=%b", i, dut_out(), 11'b0_11110_0001_0);
            else n_pass++;
            tick();
        end
        set_idle();
        hif.mem_req = 1; hif.mem_ack = 1;
        #1;
        n_checks++;
        if (dut_out() !== 11'b0_11110_0001_1) $display("FAIL timeout_err_sticky got=%b want=%b", dut_out(), 11'b0_11110_0001_1);
        else n_pass++;
        tick();
        n_checks++;
        if (hif.err !== 1'b1 || hif.stall_cnt !== 32'd6)
            $display("FAIL timeout_err_hold got=%b/%0d want=1/6", hif.err, hif.stall_cnt);
        else n_pass++;
        do_reset();
        n_checks++;
        if (hif.err !== 1'b0 || hif.stall_cnt !== 32'd0 || hif.flush_cnt !== 32'd0 || !hif.pc_we)
            $display("FAIL timeout_reset got=%b/%0d/%0d want=0/0/0", hif.err, hif.stall_cnt, hif.flush_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_during_freeze();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            hif.mem_req = 1; hif.ex_branch_taken = 1;
            #1;
            n_checks++;
            if (hif.id_flush !== 1'b0 || hif.ex_flush !== 1'b0 || dut_out() !== model_out())
                $display("FAIL branch_frozen%0d got=%b want=%b", i, dut_out(), model_out());
            else n_pass++;
            tick();
        end
        set_idle();
        hif.mem_req = 1; hif.mem_ack = 1; hif.ex_branch_taken = 1;
        #1;
        n_checks++;
        if (dut_out() !== 11'b1_00000_1100_0) $display("FAIL branch_after_ack got=%b want=%b", dut_out(), 11'b1_00000_1100_0);
        else n_pass++;
        tick();
        n_checks++;
        if (hif.flush_cnt !== 32'd1) $display("FAIL branch_freeze_flush_cnt got=%0d want=1", hif.flush_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            hif.id_rs = 5'($urandom_range(0, 3));
            hif.id_rt = 5'($urandom_range(0, 3));
            hif.id_uses_rs = 1'($urandom);
            hif.id_uses_rt = 1'($urandom);
            hif.ex_mem_re = 1'($urandom);
            hif.ex_rf_we = ($urandom_range(0, 3) != 0);
            hif.ex_rf_dst = 5'($urandom_range(0, 3));
            hif.ex_branch_taken = ($urandom_range(0, 4) == 0);
            hif.mem_req = ($urandom_range(0, 3) == 0);
            hif.mem_ack = ($urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if (dut_out() !== model_out()) $display("FAIL random_out%0d got=%b want=%b", i, dut_out(), model_out());
            else n_pass++;
            tick();
            n_checks++;
            if (hif.stall_cnt !== m_stall || hif.flush_cnt !== m_flush)
                $display("FAIL random_cnt%0d got=%0d/%0d want=%0d/%0d", i, hif.stall_cnt, hif.flush_cnt, m_stall, m_flush);
            else n_pass++;
        end
        set_idle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_waiting = 0; m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_same_cycle_ack();
        test_timeout();
        test_branch_during_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline. Drives the stall and flush inputs of the IF/ID/EX/MEM/WB pipeline registers and the PC write enable.
- Resolves three hazard sources:
  - load-use data hazards, detected between ID and EX;
  - taken branches, resolved in EX;
  - multi-cycle data-memory accesses, using a req/ack handshake in MEM.
- Adds a memory-wait FSM with a timeout and performance counters.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles before entering ERR (range 1..255).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_re  in  1  EX instruction is a load
- ex_rf_we  in  1  EX instruction writes the register file
- ex_rf_dst  in  5  EX destination register
- ex_branch_taken  in  1  EX branch/jump resolved taken this cycle
- mem_req  in  1  MEM stage issuing a data-memory access
- mem_ack  in  1  data memory completes the access this cycle
- pc_we  out  1  PC update enable
- if_stall, id_stall, ex_stall, mem_stall, wb_stall  out  1 each  hold the corresponding stage register
- id_flush, ex_flush, mem_flush, wb_flush  out  1 each  load a bubble (all-zero) into the stage register
- err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  cycles with pc_we=0
- flush_cnt  out  CNT_W  number of taken-branch flushes

Behaviour:

States: RUN, WAIT, ERR (2-bit register).

Freeze condition:
- freeze = (RUN & mem_req & ~mem_ack) | (WAIT & ~mem_ack) | ERR.
- All outputs below are combinational from the current state and inputs; zero-latency.

Priority 1, freeze:
- if_stall = id_stall = ex_stall = mem_stall = 1; pc_we = 0.
- wb_stall = 0 and wb_flush = 1, so WB receives bubbles and there is no duplicate write-back.
- All other flushes are 0. Branch and load-use detection are suppressed.
- A taken branch held in EX re-asserts after release.

Priority 2, taken branch (not frozen and ex_branch_taken):
- id_flush = ex_flush = 1; pc_we = 1, loading the target. No stalls.
- flush_cnt increments.
- A simultaneous load-use is ignored, because the ID instruction is discarded.

Priority 3, load-use:
- Detected when ex_mem_re & ex_rf_we & ex_rf_dst != 0 & ((id_uses_rs & id_rs == ex_rf_dst) | (id_uses_rt & id_rt == ex_rf_dst)).
- pc_we = 0, if_stall = id_stall = 1, ex_flush = 1 (bubble). Lasts exactly 1 cycle, since the load then moves to MEM.

Otherwise:
- All stalls and flushes are 0; pc_we = 1.

FSM transitions:
- RUN to WAIT when mem_req & ~mem_ack. A same-cycle ack (mem_req & mem_ack) stays in RUN with no freeze.
- WAIT to RUN on mem_ack. The ack cycle is not frozen, so the pipeline advances in that cycle.
- WAIT to ERR when the wait counter reaches MEM_TIMEOUT-1 with ~mem_ack.
- ERR is absorbing until rst. In ERR, err = 1 and freeze is held.

Wait counter:
- 8-bit. Cleared on entry to WAIT and in RUN; increments each WAIT cycle.
- MEM_TIMEOUT consecutive WAIT cycles without ack lead to ERR.

Counters:
- stall_cnt increments on every cycle with pc_we = 0.
- flush_cnt increments on every branch flush.
- Both wrap modulo 2^CNT_W.

Reset (rst = 1, takes effect at the next edge):
- state = RUN, wait counter = 0, err = 0, stall_cnt = 0, flush_cnt = 0.
- Combinational outputs are forced to pc_we = 0, all stalls = 0, all flushes = 0 while rst is high.
- Reset mid-WAIT or in ERR returns to RUN. The pending memory access is abandoned, and memory must drop mem_ack.

Decomposition:
- Shared package/header (PCPU.vh): state encodings HZ_RUN = 2'd0, HZ_WAIT = 2'd1, HZ_ERR = 2'd2, plus the counter width default.
- Sub-module hazard_detect (combinational load-use comparator). Everything else stays in pipe_hazard_ctrl.

Test Plan:
1. Load-use: ex_mem_re = 1, ex_rf_we = 1, ex_rf_dst = 8, id_rs = 8, id_uses_rs = 1 for 1 cycle -> pc_we = 0, if_stall = id_stall = 1, ex_flush = 1 that cycle; stall_cnt goes 0→1. Same stimulus with ex_rf_dst = 0 or id_uses_rs = 0 -> no stall.
2. Taken branch: ex_branch_taken = 1 together with a load-use match -> id_flush = ex_flush = 1, pc_we = 1, no stalls, flush_cnt = 1.
3. Memory wait: mem_req = 1, mem_ack = 0 for 3 cycles, then ack -> 3 frozen cycles, each with wb_flush = 1 and stalls = 1; the ack cycle has no freeze; state is back in RUN; stall_cnt = 3.
4. Same-cycle ack: mem_req = mem_ack = 1 -> no freeze, state stays RUN.
5. Timeout: MEM_TIMEOUT = 4, mem_req = 1, ack never arrives -> err = 1 after 1 + 4 freeze cycles; it stays 1 even when mem_ack later goes to 1; rst clears err, the state and both counters.
6. Branch during freeze: ex_branch_taken = 1 while in WAIT -> no flushes until the ack cycle, then id_flush = ex_flush = 1 and flush_cnt increments once.
